// File: rtl/burst_prbs_checker.sv
// PRBS-31 (x^31 + x^28 + 1) burst checker for realigned 32-bit RX payload words.
// Self-synchronising: the expected bits are always derived from received data.
module burst_prbs_checker #(
  parameter int CNT_W       = 32,
  parameter int LOSS_THRESH = 8,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic             rx_axis_usrclk,
  input  logic             reset_in,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             preamble_detected,
  input  logic [31:0]      burst_length,
  input  logic             clear_counters,
  output logic             checker_locked,
  output logic             burst_done,
  output logic [CNT_W-1:0] burst_count,
  output logic [CNT_W-1:0] good_burst_count,
  output logic [CNT_W-1:0] error_bit_count,
  output logic [CNT_W-1:0] sync_loss_count,
  output logic [CNT_W-1:0] last_burst_errors
);

  localparam int         GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [5:0] THRESH_W = 6'(LOSS_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_CHECK} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_locked;
  logic [GAP_W-1:0]   r_gap;
  logic [31:0]        r_wcnt;
  logic [31:0]        r_blen;
  logic [30:0]        r_hist;

  logic               r_vld_p0, r_close_p0, r_abort_p0;
  logic [31:0]        r_err_p0;
  logic               r_close_p1, r_abort_p1;
  logic [CNT_W-1:0]   r_last_p1;
  logic [CNT_W-1:0]   r_acc;

  logic               r_done;
  logic [CNT_W-1:0]   r_bcnt, r_gcnt, r_ecnt, r_scnt, r_last;

  logic [31:0]        w_exp, w_err, w_wcnt_inc;
  logic [5:0]         w_pop_now, w_add_p0;
  logic               w_thresh, w_len_hit, w_gap_last;
  logic               w_seed_acc, w_chk_acc, w_abort, w_close, w_load_len;
  logic [CNT_W-1:0]   w_acc_sum;

  // v holds history above the current word; older bits sit at higher indices.
  function automatic logic [31:0] prbs_expect(input logic [30:0] hist, input logic [31:0] data);
    logic [62:0] v;
    v = {hist, data};
    return v[62:31] ^ v[59:28];
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, x[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
    logic [CNT_W+6:0] s;
    s = {7'd0, a} + {{(CNT_W+1){1'b0}}, b};
    if (s > {7'd0, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  assign w_exp      = prbs_expect(r_hist, in_data);
  assign w_err      = in_data ^ w_exp;
  assign w_pop_now  = popcount32(w_err);
  assign w_thresh   = (w_pop_now > THRESH_W);
  assign w_wcnt_inc = r_wcnt + 32'd1;
  assign w_len_hit  = (r_blen != 32'd0) && (w_wcnt_inc == r_blen);
  assign w_gap_last = (r_gap == GAP_W'(GAP_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_seed_acc  = 1'b0;
    w_chk_acc   = 1'b0;
    w_abort     = 1'b0;
    w_close     = 1'b0;
    w_load_len  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (preamble_detected) begin
          w_state_nxt = S_SEED;
          w_load_len  = 1'b1;
        end
      end
      S_SEED: begin
        if (preamble_detected) begin
          w_abort    = 1'b1;
          w_load_len = 1'b1;
        end else if (in_valid) begin
          w_seed_acc = 1'b1;
          if (r_blen == 32'd1) begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        // An early preamble wins; the word presented alongside it is not checked.
        if (preamble_detected) begin
          w_abort     = 1'b1;
          w_load_len  = 1'b1;
          w_state_nxt = S_SEED;
        end else if (in_valid) begin
          w_chk_acc = 1'b1;
          if (w_thresh) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_len_hit) begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_gap_last) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: FSM, history and per-word error capture
  always_ff @(posedge rx_axis_usrclk) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_locked   <= 1'b0;
      r_gap      <= '0;
      r_wcnt     <= '0;
      r_blen     <= '0;
      r_hist     <= '0;
      r_vld_p0   <= 1'b0;
      r_close_p0 <= 1'b0;
      r_abort_p0 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_locked   <= (r_state == S_CHECK);
      if ((r_state == S_CHECK) && (w_state_nxt == S_CHECK) && !in_valid)
        r_gap <= r_gap + GAP_W'(1);
      else
        r_gap <= '0;
      if (w_load_len) r_blen <= burst_length;
      if (w_seed_acc) r_wcnt <= 32'd1;
      else if (w_chk_acc) r_wcnt <= w_wcnt_inc;
      if (w_seed_acc || w_chk_acc) r_hist <= in_data[30:0];
      r_vld_p0   <= w_chk_acc;
      r_close_p0 <= w_close;
      r_abort_p0 <= w_abort;
    end
  end

  always_ff @(posedge rx_axis_usrclk) begin
    r_err_p0  <= w_err;
    r_last_p1 <= w_acc_sum;
  end

  assign w_add_p0  = r_vld_p0 ? popcount32(r_err_p0) : 6'd0;
  assign w_acc_sum = sat_add(r_acc, w_add_p0);

  // Stage p1: accumulate errored bits; the accumulator restarts once a burst ends
  always_ff @(posedge rx_axis_usrclk) begin
    if (reset_in) begin
      r_acc      <= '0;
      r_ecnt     <= '0;
      r_close_p1 <= 1'b0;
      r_abort_p1 <= 1'b0;
    end else begin
      r_acc      <= (r_close_p0 || r_abort_p0) ? '0 : w_acc_sum;
      r_ecnt     <= clear_counters ? '0 : sat_add(r_ecnt, w_add_p0);
      r_close_p1 <= r_close_p0;
      r_abort_p1 <= r_abort_p0;
    end
  end

  // Stage p2: burst statistics and the done pulse
  always_ff @(posedge rx_axis_usrclk) begin
    if (reset_in) begin
      r_done <= 1'b0;
      r_bcnt <= '0;
      r_gcnt <= '0;
      r_scnt <= '0;
      r_last <= '0;
    end else begin
      r_done <= r_close_p1;
      if (clear_counters) begin
        r_bcnt <= '0;
        r_gcnt <= '0;
        r_scnt <= '0;
        r_last <= '0;
      end else begin
        if (r_close_p1) r_bcnt <= sat_add(r_bcnt, 6'd1);
        if (r_close_p1 && (r_last_p1 == '0)) r_gcnt <= sat_add(r_gcnt, 6'd1);
        if (r_abort_p1) r_scnt <= sat_add(r_scnt, 6'd1);
        if (r_close_p1 || r_abort_p1) r_last <= r_last_p1;
      end
    end
  end

  assign checker_locked    = r_locked;
  assign burst_done        = r_done;
  assign burst_count       = r_bcnt;
  assign good_burst_count  = r_gcnt;
  assign error_bit_count   = r_ecnt;
  assign sync_loss_count   = r_scnt;
  assign last_burst_errors = r_last;

endmodule

// File: tb/tb_burst_prbs_checker.sv
// Directed bench for burst_prbs_checker; a second instance with 3-bit counters
// exercises counter saturation on the same stimulus.
module tb_burst_prbs_checker;

  logic        clk = 1'b0;
  logic        reset_in, in_valid, preamble_detected, clear_counters;
  logic [31:0] in_data, burst_length;

  logic        checker_locked, burst_done;
  logic [31:0] burst_count, good_burst_count, error_bit_count, sync_loss_count, last_burst_errors;

  logic        s_locked, s_done;
  logic [2:0]  s_bc, s_gbc, s_ebc, s_slc, s_last;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  logic [30:0] lfsr = 31'h2AC3_5F17;

  always #5 clk = ~clk;

  burst_prbs_checker dut (
    .rx_axis_usrclk(clk), .reset_in(reset_in), .in_data(in_data), .in_valid(in_valid),
    .preamble_detected(preamble_detected), .burst_length(burst_length),
    .clear_counters(clear_counters), .checker_locked(checker_locked), .burst_done(burst_done),
    .burst_count(burst_count), .good_burst_count(good_burst_count),
    .error_bit_count(error_bit_count), .sync_loss_count(sync_loss_count),
    .last_burst_errors(last_burst_errors)
  );

  burst_prbs_checker #(.CNT_W(3)) u_sat (
    .rx_axis_usrclk(clk), .reset_in(reset_in), .in_data(in_data), .in_valid(in_valid),
    .preamble_detected(preamble_detected), .burst_length(burst_length),
    .clear_counters(clear_counters), .checker_locked(s_locked), .burst_done(s_done),
    .burst_count(s_bc), .good_burst_count(s_gbc), .error_bit_count(s_ebc),
    .sync_loss_count(s_slc), .last_burst_errors(s_last)
  );

  always @(negedge clk) if (burst_done === 1'b1) done_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    preamble_detected = 1'b0;
    repeat (n) step();
  endtask

  // Serial PRBS-31 source: each new bit is s[n-31] ^ s[n-28], bit 31 sent first.
  task automatic gen_word(output logic [31:0] w);
    logic nb;
    for (int i = 31; i >= 0; i--) begin
      nb = lfsr[30] ^ lfsr[27];
      lfsr = {lfsr[29:0], nb};
      w[i] = nb;
    end
  endtask

  task automatic send_words(input int n);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      gen_word(w);
      in_data = w;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_burst(input int n, input int bad_idx, input logic [31:0] bad_mask,
                           input int gap_idx, input int gap_len);
    logic [31:0] w;
    preamble_detected = 1'b1;
    in_valid = 1'b0;
    step();
    preamble_detected = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_idx) begin
        in_valid = 1'b0;
        repeat (gap_len) step();
      end
      gen_word(w);
      if (k == bad_idx) w = w ^ bad_mask;
      in_data = w;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset_in = 1'b1;
    in_valid = 1'b0;
    preamble_detected = 1'b0;
    clear_counters = 1'b0;
    in_data = '0;
    burst_length = 32'd100;
    repeat (3) step();
    reset_in = 1'b0;
    step();
    chk("reset_locked", checker_locked, 0);
    chk("reset_done", burst_done, 0);
    chk("reset_bc", burst_count, 0);
    chk("reset_gbc", good_burst_count, 0);
    chk("reset_ebc", error_bit_count, 0);
    chk("reset_slc", sync_loss_count, 0);
    chk("reset_last", last_burst_errors, 0);

    // clean burst with close latency
    run_burst(100, -1, 32'h0, -1, 0);
    chk("lat_done_e0", burst_done, 0);
    chk("lat_bc_e0", burst_count, 0);
    idle(1);
    chk("lat_done_e1", burst_done, 0);
    idle(1);
    chk("lat_done_e2", burst_done, 1);
    chk("lat_bc_e2", burst_count, 1);
    idle(1);
    chk("lat_done_pulse", burst_done, 0);
    run_burst(100, -1, 32'h0, -1, 0);
    idle(3);
    run_burst(100, -1, 32'h0, -1, 0);
    idle(3);
    chk("clean_bc", burst_count, 3);
    chk("clean_gbc", good_burst_count, 3);
    chk("clean_ebc", error_bit_count, 0);
    chk("clean_slc", sync_loss_count, 0);
    chk("clean_pulses", done_pulses, 3);

    // bit 5 of word 40: errors at word40 bit5, word41 bits 6 and 9
    run_burst(100, 40, 32'h0000_0020, -1, 0);
    idle(3);
    chk("inj_bc", burst_count, 4);
    chk("inj_gbc", good_burst_count, 3);
    chk("inj_ebc", error_bit_count, 3);
    chk("inj_last", last_burst_errors, 3);
    chk("inj_sat_ebc", s_ebc, 3);

    // bit 31 of the first checked word: all three errors land in that word
    run_burst(100, 1, 32'h8000_0000, -1, 0);
    idle(3);
    chk("inj31_ebc", error_bit_count, 6);
    chk("inj31_last", last_burst_errors, 3);
    chk("sat_ebc_pre", s_ebc, 6);
    run_burst(100, 40, 32'h0000_0020, -1, 0);
    idle(3);
    chk("inj2_ebc", error_bit_count, 9);
    chk("sat_ebc_hold", s_ebc, 7);

    // 16 flipped bits plus 3 self-sync echoes inside the same word = 19
    run_burst(11, 10, 32'hFFFF_0000, -1, 0);
    chk("thr_locked_e0", checker_locked, 1);
    idle(1);
    chk("thr_locked_e1", checker_locked, 0);
    idle(3);
    chk("thr_slc", sync_loss_count, 1);
    chk("thr_last", last_burst_errors, 19);
    chk("thr_ebc", error_bit_count, 28);
    chk("thr_bc", burst_count, 6);
    chk("thr_pulses", done_pulses, 6);

    run_burst(100, -1, 32'h0, 30, 64);
    idle(3);
    chk("gap64_slc", sync_loss_count, 2);
    chk("gap64_bc", burst_count, 6);
    chk("gap64_last", last_burst_errors, 0);
    run_burst(100, -1, 32'h0, 30, 63);
    idle(3);
    chk("gap63_bc", burst_count, 7);
    chk("gap63_gbc", good_burst_count, 4);
    chk("gap63_slc", sync_loss_count, 2);

    run_burst(50, -1, 32'h0, -1, 0);
    run_burst(100, -1, 32'h0, -1, 0);
    idle(3);
    chk("repre_slc", sync_loss_count, 3);
    chk("repre_bc", burst_count, 8);
    chk("repre_gbc", good_burst_count, 5);

    // continuous mode; a mid-burst length change must not close this burst
    burst_length = 32'd0;
    run_burst(3, -1, 32'h0, -1, 0);
    burst_length = 32'd5;
    send_words(147);
    chk("cont_locked", checker_locked, 1);
    chk("cont_bc", burst_count, 8);
    idle(70);
    chk("cont_slc", sync_loss_count, 4);
    chk("cont_locked_off", checker_locked, 0);
    chk("cont_pulses", done_pulses, 8);

    burst_length = 32'd1;
    run_burst(1, -1, 32'h0, -1, 0);
    idle(3);
    chk("len1_bc", burst_count, 9);
    chk("len1_gbc", good_burst_count, 6);
    burst_length = 32'd100;

    // clear lands on the same edge as the close
    run_burst(100, -1, 32'h0, -1, 0);
    idle(1);
    clear_counters = 1'b1;
    step();
    clear_counters = 1'b0;
    chk("clr_done", burst_done, 1);
    chk("clr_bc", burst_count, 0);
    chk("clr_gbc", good_burst_count, 0);
    chk("clr_ebc", error_bit_count, 0);
    chk("clr_slc", sync_loss_count, 0);
    chk("clr_last", last_burst_errors, 0);
    idle(3);
    chk("clr_pulses", done_pulses, 10);

    run_burst(20, 5, 32'h0000_0001, -1, 0);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    chk("rst_mid_locked", checker_locked, 0);
    send_words(80);
    idle(3);
    chk("rst_mid_bc", burst_count, 0);
    chk("rst_mid_ebc", error_bit_count, 0);
    chk("rst_mid_pulses", done_pulses, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
